// File: rtl/data_mem_bridge_pkg.sv
// Shared encodings and constants for the cpu data-port to data-memory bridge.
// The LED register decode address and the fill pattern returned on a timed-out load live here.
package data_mem_bridge_pkg;

  typedef enum logic [1:0] {
    BRIDGE_IDLE = 2'd0,
    BRIDGE_REQ  = 2'd1,
    BRIDGE_DONE = 2'd2
  } bridge_state_e;

  localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_2000;

  // A timed-out load returns this bit replicated across the whole data word.
  localparam logic TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/data_mem_bridge_wait_timer.sv
// Wait-state counter for the bridge: cleared when a request launches, counts while
// the request is outstanding, and flags expiry on the cycle it would reach MAX_WAIT.
module bridge_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_WAIT);

  logic [CW-1:0] count_q;

  // Expiry is taken on the edge that moves the count onto MAX_WAIT.
  assign expire = count_en && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en && (count_q != FULL)) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges single-cycle cpu load/store strobes onto a req/ack data memory,
// stalling the cpu via clock-enable, with a zero-wait LED register and wait timeout.
//
// state       | meaning
// BRIDGE_IDLE | no access outstanding; LED hits complete here, others launch
// BRIDGE_REQ  | mem_req held with stable address/data until ack or timeout
// BRIDGE_DONE | one unstalled cycle presenting the result; strobes ignored
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LED_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] LED_ADDR = ADDR_WIDTH'(LED_ADDR_DEFAULT),
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_memread,
  input  logic                  cpu_memwrite,
  input  logic [3:0]            cpu_sign_mask,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_sign_mask,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [LED_WIDTH-1:0]  led_o,
  output logic                  err_timeout
);

  bridge_state_e         state;
  logic                  access;
  logic                  led_hit;
  logic                  launch;
  logic                  expire;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [LED_WIDTH-1:0]  led_q;

  assign access  = cpu_memread | cpu_memwrite;
  assign led_hit = access && (cpu_addr[ADDR_WIDTH-1:2] == LED_ADDR[ADDR_WIDTH-1:2]);
  assign launch  = (state == BRIDGE_IDLE) && access && !led_hit;

  // The launch cycle must stall combinationally so the cpu holds its strobes into REQ.
  assign cpu_stall = !reset && (launch || (state == BRIDGE_REQ));

  assign cpu_rdata = ((state == BRIDGE_IDLE) && led_hit && cpu_memread)
                     ? DATA_WIDTH'(led_q) : rdata_q;
  assign led_o = led_q;

  bridge_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (launch),
    .count_en(state == BRIDGE_REQ),
    .expire  (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BRIDGE_IDLE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_sign_mask <= '0;
      rdata_q       <= '0;
      led_q         <= '0;
      err_timeout   <= 1'b0;
    end else begin
      unique case (state)
        BRIDGE_IDLE: begin
          if (led_hit) begin
            if (cpu_memwrite) led_q <= cpu_wdata[LED_WIDTH-1:0];
          end else if (access) begin
            state         <= BRIDGE_REQ;
            mem_req       <= 1'b1;
            mem_we        <= cpu_memwrite;
            mem_addr      <= cpu_addr;
            mem_wdata     <= cpu_wdata;
            mem_sign_mask <= cpu_sign_mask;
          end
        end
        BRIDGE_REQ: begin
          // Ack takes priority over a simultaneous expiry.
          if (mem_ack) begin
            if (!mem_we) rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= BRIDGE_DONE;
          end else if (expire) begin
            rdata_q     <= {DATA_WIDTH{TIMEOUT_FILL}};
            err_timeout <= 1'b1;
            mem_req     <= 1'b0;
            state       <= BRIDGE_DONE;
          end
        end
        BRIDGE_DONE: begin
          state <= BRIDGE_IDLE;
        end
        default: begin
          state   <= BRIDGE_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed self-checking bench for data_mem_bridge with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_memread;
  logic        cpu_memwrite;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sign_mask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [7:0]  led_o;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] LED_A = 32'h0000_2000;

  data_mem_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_memread  (cpu_memread),
    .cpu_memwrite (cpu_memwrite),
    .cpu_sign_mask(cpu_sign_mask),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_sign_mask(mem_sign_mask),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .led_o        (led_o),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    cyc();
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b0;
    mem_ack      = 1'b0;
    #1;
  endtask

  // Presents one access at cycle 0, holds the strobes for ncyc cycles, pulses ack at
  // cycle ack_at (negative = never) and collects what the bridge did along the way.
  task automatic drive_access(
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  int          ack_at,
    input  logic [31:0] ack_data,
    input  int          ncyc,
    output int          stalls,
    output int          reqs,
    output logic        we_seen,
    output logic        held_ok,
    output logic        last_stall,
    output logic [31:0] last_rdata
  );
    stalls = 0;
    reqs = 0;
    we_seen = 1'b0;
    held_ok = 1'b1;
    last_stall = 1'b0;
    last_rdata = '0;
    for (int i = 0; i < ncyc; i++) begin
      cyc();
      if (i == 0) begin
        cpu_addr      = addr;
        cpu_wdata     = wdata;
        cpu_memread   = rd;
        cpu_memwrite  = wr;
        cpu_sign_mask = mask;
      end
      mem_ack   = (i == ack_at);
      mem_rdata = (i == ack_at) ? ack_data : 32'h5A5A_5A5A;
      #1;
      stalls += int'(cpu_stall);
      reqs   += int'(mem_req);
      if (mem_req) begin
        we_seen = we_seen | mem_we;
        if (mem_addr !== addr || mem_wdata !== wdata || mem_sign_mask !== mask)
          held_ok = 1'b0;
      end
      last_stall = cpu_stall;
      last_rdata = cpu_rdata;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_addr = 32'h100;
    cpu_wdata = '0;
    cpu_memread = 1'b1;
    cpu_memwrite = 1'b0;
    cpu_sign_mask = 4'hF;
    mem_ack = 1'b0;
    mem_rdata = '0;
    cyc();
    cyc();
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL reset_led got %h exp 00", led_o); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_timeout); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", cpu_rdata); end
    cpu_memread = 1'b0;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_load();
    int s, r;
    logic we, ok, ls;
    logic [31:0] rd;
    drive_access(32'h100, 32'h0, 1'b1, 1'b0, 4'hF, 3, 32'hDEAD_BEEF, 5, s, r, we, ok, ls, rd);
    checks++; if (s != 4) begin errors++; $display("FAIL load_stall_cycles got %0d exp 4", s); end
    checks++; if (r != 3) begin errors++; $display("FAIL load_req_cycles got %0d exp 3", r); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL load_we got %b exp 0", we); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL load_held got %b exp 1", ok); end
    checks++; if (ls !== 1'b0) begin errors++; $display("FAIL load_done_stall got %b exp 0", ls); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", rd); end
    go_idle();
  endtask

  task automatic test_led();
    cyc();
    cpu_addr = LED_A;
    cpu_wdata = 32'h0000_00A5;
    cpu_memwrite = 1'b1;
    cpu_memread = 1'b0;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL led_wr_stall got %b exp 0", cpu_stall); end
    checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL led_before_edge got %h exp 00", led_o); end
    cyc();
    cpu_memwrite = 1'b0;
    cpu_memread = 1'b1;
    cpu_addr = LED_A + 32'd2;
    #1;
    checks++; if (led_o !== 8'hA5) begin errors++; $display("FAIL led_value got %h exp a5", led_o); end
    checks++; if (cpu_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL led_read got %h exp 000000a5", cpu_rdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL led_rd_stall got %b exp 0", cpu_stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL led_req got %b exp 0", mem_req); end
    go_idle();
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL led_after_rdata got %h exp deadbeef", cpu_rdata); end
  endtask

  task automatic test_store();
    int s, r;
    logic we, ok, ls;
    logic [31:0] rd;
    drive_access(32'h40, 32'h1234_5678, 1'b0, 1'b1, 4'b0011, 1, 32'hCAFE_0000, 3, s, r, we, ok, ls, rd);
    checks++; if (s != 2) begin errors++; $display("FAIL store_stall_cycles got %0d exp 2", s); end
    checks++; if (r != 1) begin errors++; $display("FAIL store_req_cycles got %0d exp 1", r); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL store_we got %b exp 1", we); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL store_held got %b exp 1", ok); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_rdata_kept got %h exp deadbeef", rd); end
    go_idle();
  endtask

  task automatic test_ack_at_expiry();
    int s, r;
    logic we, ok, ls;
    logic [31:0] rd;
    drive_access(32'h180, 32'h0, 1'b1, 1'b0, 4'hF, 15, 32'h0F0F_1234, 17, s, r, we, ok, ls, rd);
    checks++; if (s != 16) begin errors++; $display("FAIL tie_stall_cycles got %0d exp 16", s); end
    checks++; if (rd !== 32'h0F0F_1234) begin errors++; $display("FAIL tie_rdata got %h exp 0f0f1234", rd); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tie_err got %b exp 0", err_timeout); end
    go_idle();
  endtask

  task automatic test_timeout();
    int s, r;
    logic we, ok, ls;
    logic [31:0] rd;
    drive_access(32'h80, 32'h0, 1'b1, 1'b0, 4'hF, -1, 32'h0, 17, s, r, we, ok, ls, rd);
    checks++; if (s != 16) begin errors++; $display("FAIL to_stall_cycles got %0d exp 16", s); end
    checks++; if (r != 15) begin errors++; $display("FAIL to_req_cycles got %0d exp 15", r); end
    checks++; if (ls !== 1'b0) begin errors++; $display("FAIL to_done_stall got %b exp 0", ls); end
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_rdata got %h exp ffffffff", rd); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err_timeout); end
    go_idle();
    drive_access(32'h84, 32'h0, 1'b1, 1'b0, 4'hF, 2, 32'h0BAD_F00D, 4, s, r, we, ok, ls, rd);
    checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL to_next_rdata got %h exp 0badf00d", rd); end
    checks++; if (s != 3) begin errors++; $display("FAIL to_next_stall got %0d exp 3", s); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %b exp 1", err_timeout); end
    go_idle();
  endtask

  task automatic test_reset_mid_req();
    cyc();
    cpu_addr = 32'h200;
    cpu_memread = 1'b1;
    #1;
    cyc();
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got %b exp 1", mem_req); end
    cyc();
    reset = 1'b1;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall_in_reset got %b exp 0", cpu_stall); end
    cyc();
    reset = 1'b0;
    cpu_memread = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h7777_7777;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mem_req); end
    checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL rst_led got %h exp 00", led_o); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_timeout); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", cpu_stall); end
    cyc();
    mem_ack = 1'b0;
    #1;
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_ack_ignored got %h exp 0", cpu_rdata); end
    checks++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL rst_idle_after got req=%b stall=%b exp 0 0", mem_req, cpu_stall);
    end
  endtask

  task automatic test_back_to_back();
    int s, r, total;
    logic we, ok, ls;
    logic [31:0] rd;
    drive_access(32'h300, 32'h0, 1'b1, 1'b0, 4'hF, 1, 32'h1111_1111, 3, s, r, we, ok, ls, rd);
    total = r;
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL b2b_first got %h exp 11111111", rd); end
    drive_access(32'h304, 32'h0, 1'b1, 1'b0, 4'hF, 1, 32'h2222_2222, 3, s, r, we, ok, ls, rd);
    total += r;
    checks++; if (rd !== 32'h2222_2222) begin errors++; $display("FAIL b2b_second got %h exp 22222222", rd); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_second_addr got %b exp 1", ok); end
    checks++; if (total != 2) begin errors++; $display("FAIL b2b_req_cycles got %0d exp 2", total); end
    go_idle();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL b2b_done_launch got %b exp 0", mem_req); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_led();
    test_store();
    test_ack_at_expiry();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
